// File: rtl/line_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : line_arb_pkg
// Purpose : Shared state encoding and default widths for the line bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package line_arb_pkg;

    localparam int c_AW_DEF = 32;
    localparam int c_DW_DEF = 128;
    localparam int c_MW_DEF = c_DW_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_W = 2'd2,
        ST_WAIT_R = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/line_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : line_bus_arbiter_if
// Purpose : Upstream per-channel request bus plus single downstream line bus.
// Revision: 1.0 - initial release
// ============================================================================
interface line_bus_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = line_arb_pkg::c_AW_DEF,
    parameter int DW  = line_arb_pkg::c_DW_DEF,
    parameter int MW  = DW / 8
);
    logic [NCH-1:0]    s_wstart_rq;
    logic [NCH-1:0]    s_rstart_rq;
    logic [NCH*AW-1:0] s_win_addr;
    logic [NCH*AW-1:0] s_rin_addr;
    logic [NCH*DW-1:0] s_in_wdata;
    logic [NCH*MW-1:0] s_in_mask;
    logic [NCH-1:0]    s_finish_wresp;
    logic [NCH-1:0]    s_finish_mrd;
    logic [DW-1:0]     s_rdat_m_data;
    logic [NCH-1:0]    s_rdat_m_valid;
    logic [NCH-1:0]    s_rqfull;
    logic [NCH-1:0]    s_ovf;

    logic              m_wstart_rq;
    logic [AW-1:0]     m_win_addr;
    logic [DW-1:0]     m_in_wdata;
    logic [MW-1:0]     m_in_mask;
    logic              m_rstart_rq;
    logic [AW-1:0]     m_rin_addr;
    logic              m_finish_wresp;
    logic [DW-1:0]     m_rdat_m_data;
    logic              m_rdat_m_valid;
    logic              m_finish_mrd;

    // Arbiter view: accepts upstream requests, drives the downstream bus.
    modport slave (
        input  s_wstart_rq, s_rstart_rq, s_win_addr, s_rin_addr, s_in_wdata, s_in_mask,
        output s_finish_wresp, s_finish_mrd, s_rdat_m_data, s_rdat_m_valid, s_rqfull, s_ovf,
        output m_wstart_rq, m_win_addr, m_in_wdata, m_in_mask, m_rstart_rq, m_rin_addr,
        input  m_finish_wresp, m_rdat_m_data, m_rdat_m_valid, m_finish_mrd
    );

    // Environment view: requesters plus downstream memory model.
    modport master (
        output s_wstart_rq, s_rstart_rq, s_win_addr, s_rin_addr, s_in_wdata, s_in_mask,
        input  s_finish_wresp, s_finish_mrd, s_rdat_m_data, s_rdat_m_valid, s_rqfull, s_ovf,
        input  m_wstart_rq, m_win_addr, m_in_wdata, m_in_mask, m_rstart_rq, m_rin_addr,
        output m_finish_wresp, m_rdat_m_data, m_rdat_m_valid, m_finish_mrd
    );
endinterface
`default_nettype wire

// File: rtl/line_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Purpose : Round-robin selection starting one past the last grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter  int NCH = 2,
    localparam int LW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  wire logic [NCH-1:0] i_req,
    input  wire logic [LW-1:0]  i_last,
    output logic      [NCH-1:0] o_grant,
    output logic                o_valid
);
    logic [LW:0]      w_shift;
    logic [2*NCH-1:0] w_req2;
    logic [NCH-1:0]   w_rot;
    logic [NCH-1:0]   w_pick;
    logic [2*NCH-1:0] w_back;

    // Rotate so that channel last+1 sits at bit 0, take the lowest set bit, rotate back.
    assign w_shift = {1'b0, i_last} + {{LW{1'b0}}, 1'b1};
    assign w_req2  = {i_req, i_req} >> w_shift;
    assign w_rot   = w_req2[NCH-1:0];
    assign w_pick  = w_rot & (~w_rot + {{(NCH-1){1'b0}}, 1'b1});
    assign w_back  = {{NCH{1'b0}}, w_pick} << w_shift;
    assign o_grant = w_back[NCH-1:0] | w_back[2*NCH-1:NCH];
    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/line_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : line_bus_arbiter
// Purpose : Arbitrates NCH line read/write requesters onto one downstream bus.
// Revision: 1.0 - initial release
// ============================================================================
module line_bus_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = line_arb_pkg::c_AW_DEF,
    parameter int DW  = line_arb_pkg::c_DW_DEF,
    parameter int MW  = DW / 8
) (
    input wire logic         clk,
    input wire logic         rst,
    line_bus_arbiter_if.slave bus
);
    import line_arb_pkg::*;

    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;

    logic [NCH-1:0] r_wpend;
    logic [NCH-1:0] r_rpend;
    logic [NCH-1:0] r_ovf;
    logic [NCH-1:0] r_fin_w;
    logic [NCH-1:0] r_fin_r;
    logic [AW-1:0]  r_waddr [NCH];
    logic [AW-1:0]  r_raddr [NCH];
    logic [DW-1:0]  r_wdata [NCH];
    logic [MW-1:0]  r_mask  [NCH];

    logic [LW-1:0]  r_grant;
    logic           r_is_wr;
    logic [AW-1:0]  r_m_waddr;
    logic [AW-1:0]  r_m_raddr;
    logic [DW-1:0]  r_m_wdata;
    logic [MW-1:0]  r_m_mask;

    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_pick;
    logic           w_pick_valid;
    logic [LW-1:0]  w_pick_idx;
    logic [NCH-1:0] w_grant_oh;
    logic [NCH-1:0] w_clr_w;
    logic [NCH-1:0] w_clr_r;
    logic [NCH-1:0] w_remain;
    logic [NCH-1:0] w_start;
    logic [NCH-1:0] w_accept;
    logic           w_grab;

    assign w_req      = r_wpend | r_rpend;
    assign w_grant_oh = {{(NCH-1){1'b0}}, 1'b1} << r_grant;
    assign w_clr_w    = (r_state == ST_WAIT_W && bus.m_finish_wresp) ? w_grant_oh : '0;
    assign w_clr_r    = (r_state == ST_WAIT_R && bus.m_finish_mrd)   ? w_grant_oh : '0;
    // A pulse on a channel whose last pending bit is clearing this cycle is accepted.
    assign w_remain   = (r_wpend & ~w_clr_w) | (r_rpend & ~w_clr_r);
    assign w_start    = bus.s_wstart_rq | bus.s_rstart_rq;
    assign w_accept   = w_start & ~w_remain;
    assign w_grab     = (r_state == ST_IDLE) && w_pick_valid;

    rr_picker #(.NCH(NCH)) u_rr_picker (
        .i_req   (w_req),
        .i_last  (r_grant),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_pick[i]) w_pick_idx = LW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        bus.m_wstart_rq    = 1'b0;
        bus.m_rstart_rq    = 1'b0;
        bus.s_rdat_m_valid = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.m_wstart_rq = r_is_wr;
                bus.m_rstart_rq = ~r_is_wr;
                w_state_nxt     = r_is_wr ? ST_WAIT_W : ST_WAIT_R;
            end
            ST_WAIT_W: begin
                if (bus.m_finish_wresp) w_state_nxt = ST_IDLE;
            end
            ST_WAIT_R: begin
                if (bus.m_rdat_m_valid) bus.s_rdat_m_valid = w_grant_oh;
                if (bus.m_finish_mrd)   w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant and downstream payload are captured together so the bus holds steady until IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= LW'(NCH - 1);
            r_is_wr   <= 1'b0;
            r_m_waddr <= '0;
            r_m_raddr <= '0;
            r_m_wdata <= '0;
            r_m_mask  <= '0;
        end else if (w_grab) begin
            r_grant   <= w_pick_idx;
            r_is_wr   <= |(w_pick & r_wpend);
            r_m_waddr <= r_waddr[w_pick_idx];
            r_m_raddr <= r_raddr[w_pick_idx];
            r_m_wdata <= r_wdata[w_pick_idx];
            r_m_mask  <= r_mask[w_pick_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wpend <= '0;
            r_rpend <= '0;
            r_ovf   <= '0;
            r_fin_w <= '0;
            r_fin_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_waddr[i] <= '0;
                r_raddr[i] <= '0;
                r_wdata[i] <= '0;
                r_mask[i]  <= '0;
            end
        end else begin
            r_fin_w <= w_clr_w;
            r_fin_r <= w_clr_r;
            for (int i = 0; i < NCH; i++) begin
                if (w_accept[i]) begin
                    r_wpend[i] <= bus.s_wstart_rq[i];
                    r_rpend[i] <= bus.s_rstart_rq[i];
                    if (bus.s_wstart_rq[i]) begin
                        r_waddr[i] <= bus.s_win_addr[i*AW +: AW];
                        r_wdata[i] <= bus.s_in_wdata[i*DW +: DW];
                        r_mask[i]  <= bus.s_in_mask[i*MW +: MW];
                    end
                    if (bus.s_rstart_rq[i]) r_raddr[i] <= bus.s_rin_addr[i*AW +: AW];
                end else begin
                    r_wpend[i] <= r_wpend[i] & ~w_clr_w[i];
                    r_rpend[i] <= r_rpend[i] & ~w_clr_r[i];
                end
                if (w_start[i] && !w_accept[i]) r_ovf[i] <= 1'b1;
            end
        end
    end

    assign bus.s_finish_wresp = r_fin_w;
    assign bus.s_finish_mrd   = r_fin_r;
    assign bus.s_rdat_m_data  = bus.m_rdat_m_data;
    assign bus.s_rqfull       = r_wpend | r_rpend;
    assign bus.s_ovf          = r_ovf;
    assign bus.m_win_addr     = r_m_waddr;
    assign bus.m_rin_addr     = r_m_raddr;
    assign bus.m_in_wdata     = r_m_wdata;
    assign bus.m_in_mask      = r_m_mask;

endmodule
`default_nettype wire

// File: tb/tb_line_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_line_bus_arbiter
// Purpose : Directed and randomized checks of line_bus_arbiter (NCH=2 and NCH=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_line_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic rst2;
    logic rst4;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int model_last;

    typedef struct {
        int            ch;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } txn_t;

    txn_t          exp_q[$];
    logic [AW-1:0] m_wa [4];
    logic [AW-1:0] m_ra [4];
    logic [DW-1:0] m_wd [4];
    logic [MW-1:0] m_mk [4];

    line_bus_arbiter_if #(.NCH(2), .AW(AW), .DW(DW), .MW(MW)) b2 ();
    line_bus_arbiter_if #(.NCH(4), .AW(AW), .DW(DW), .MW(MW)) b4 ();

    line_bus_arbiter #(.NCH(2), .AW(AW), .DW(DW), .MW(MW)) u_dut2 (.clk(clk), .rst(rst2), .bus(b2));
    line_bus_arbiter #(.NCH(4), .AW(AW), .DW(DW), .MW(MW)) u_dut4 (.clk(clk), .rst(rst4), .bus(b4));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive4(input logic [3:0] pw, input logic [3:0] pr);
        b4.s_wstart_rq = pw;
        b4.s_rstart_rq = pr;
        for (int c = 0; c < 4; c++) begin
            b4.s_win_addr[c*AW +: AW] = m_wa[c];
            b4.s_rin_addr[c*AW +: AW] = m_ra[c];
            b4.s_in_wdata[c*DW +: DW] = m_wd[c];
            b4.s_in_mask[c*MW +: MW]  = m_mk[c];
        end
        tick();
        b4.s_wstart_rq = '0;
        b4.s_rstart_rq = '0;
    endtask

    // Acts as the downstream memory for one expected transaction on the NCH=4 instance.
    task automatic serve4(input txn_t t);
        int            waitc;
        int            nb;
        logic [DW-1:0] beat;
        logic [3:0]    oh;
        waitc = 0;
        oh    = 4'b0001 << t.ch;
        while (!(b4.m_wstart_rq || b4.m_rstart_rq) && waitc < 30) begin
            tick();
            waitc++;
        end
        check("issue_in_time", 128'(waitc < 30), 128'(1));
        if (waitc >= 30) return;
        check("issue_is_write", 128'(b4.m_wstart_rq), 128'(t.wr));
        check("issue_single_type", 128'(b4.m_wstart_rq & b4.m_rstart_rq), 128'(0));
        if (t.wr) begin
            check("issue_waddr", 128'(b4.m_win_addr), 128'(t.addr));
            check("issue_wdata", b4.m_in_wdata, t.data);
            check("issue_mask", 128'(b4.m_in_mask), 128'(t.mask));
        end else begin
            check("issue_raddr", 128'(b4.m_rin_addr), 128'(t.addr));
        end
        tick();
        check("issue_one_cycle", 128'({b4.m_wstart_rq, b4.m_rstart_rq}), 128'(0));
        repeat ($urandom_range(0, 3)) tick();
        if (!t.wr) begin
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) begin
                beat = rnd128();
                b4.m_rdat_m_valid = 1'b1;
                b4.m_rdat_m_data  = beat;
                #1;
                check("beat_valid", 128'(b4.s_rdat_m_valid), 128'(oh));
                check("beat_data", b4.s_rdat_m_data, beat);
                tick();
                b4.m_rdat_m_valid = 1'b0;
            end
        end
        if (t.wr) b4.m_finish_wresp = 1'b1;
        else      b4.m_finish_mrd   = 1'b1;
        #1;
        check("finish_not_early", 128'({b4.s_finish_wresp, b4.s_finish_mrd}), 128'(0));
        tick();
        b4.m_finish_wresp = 1'b0;
        b4.m_finish_mrd   = 1'b0;
        check("finish_wresp", 128'(b4.s_finish_wresp), 128'(t.wr ? oh : 4'b0000));
        check("finish_mrd", 128'(b4.s_finish_mrd), 128'(t.wr ? 4'b0000 : oh));
        tick();
        check("finish_one_cycle", 128'({b4.s_finish_wresp, b4.s_finish_mrd}), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wd;
        logic [DW-1:0] beat;
        logic [5:0]    pattern;
        logic [3:0]    pw;
        logic [3:0]    pr;
        int            beats;
        int            starts;
        int            kind;
        int            sel;
        txn_t          t;

        rst2 = 1'b1;
        rst4 = 1'b1;
        b2.s_wstart_rq = '0; b2.s_rstart_rq = '0; b2.s_win_addr = '0; b2.s_rin_addr = '0;
        b2.s_in_wdata = '0; b2.s_in_mask = '0; b2.m_finish_wresp = 1'b0; b2.m_rdat_m_data = '0;
        b2.m_rdat_m_valid = 1'b0; b2.m_finish_mrd = 1'b0;
        b4.s_wstart_rq = '0; b4.s_rstart_rq = '0; b4.s_win_addr = '0; b4.s_rin_addr = '0;
        b4.s_in_wdata = '0; b4.s_in_mask = '0; b4.m_finish_wresp = 1'b0; b4.m_rdat_m_data = '0;
        b4.m_rdat_m_valid = 1'b0; b4.m_finish_mrd = 1'b0;
        tick(); tick();
        rst2 = 1'b0;
        rst4 = 1'b0;
        tick();

        check("rst_rqfull", 128'(b2.s_rqfull), 128'(0));
        check("rst_ovf", 128'(b2.s_ovf), 128'(0));
        check("rst_starts", 128'({b2.m_wstart_rq, b2.m_rstart_rq}), 128'(0));
        check("rst_finish", 128'({b2.s_finish_wresp, b2.s_finish_mrd}), 128'(0));
        check("rst_waddr", 128'(b2.m_win_addr), 128'(0));
        check("rst_wdata", b2.m_in_wdata, 128'(0));

        // Single ch0 write: start at cycle 2, finish at 6 gives s_finish_wresp at 7.
        wd = rnd128();
        b2.s_wstart_rq = 2'b01;
        b2.s_win_addr  = {32'h0, 32'h0000_1000};
        b2.s_in_wdata  = {128'h0, wd};
        b2.s_in_mask   = {16'h0, 16'hFFFF};
        tick();
        b2.s_wstart_rq = 2'b00;
        check("w_c1_rqfull", 128'(b2.s_rqfull), 128'(2'b01));
        check("w_c1_nostart", 128'(b2.m_wstart_rq), 128'(0));
        tick();
        check("w_c2_start", 128'(b2.m_wstart_rq), 128'(1));
        check("w_c2_rstart", 128'(b2.m_rstart_rq), 128'(0));
        check("w_c2_addr", 128'(b2.m_win_addr), 128'(32'h0000_1000));
        check("w_c2_mask", 128'(b2.m_in_mask), 128'(16'hFFFF));
        check("w_c2_data", b2.m_in_wdata, wd);
        tick();
        check("w_c3_start", 128'(b2.m_wstart_rq), 128'(0));
        check("w_c3_addr_hold", 128'(b2.m_win_addr), 128'(32'h0000_1000));
        tick(); tick(); tick();
        b2.m_finish_wresp = 1'b1;
        #1;
        check("w_c6_fin", 128'(b2.s_finish_wresp), 128'(0));
        tick();
        b2.m_finish_wresp = 1'b0;
        check("w_c7_fin", 128'(b2.s_finish_wresp), 128'(2'b01));
        check("w_c7_rqfull", 128'(b2.s_rqfull), 128'(0));
        tick();
        check("w_c8_fin", 128'(b2.s_finish_wresp), 128'(0));

        // Downstream responses while IDLE must be ignored.
        b2.m_rdat_m_valid = 1'b1;
        b2.m_finish_mrd   = 1'b1;
        b2.m_finish_wresp = 1'b1;
        #1;
        check("idle_valid_ignored", 128'(b2.s_rdat_m_valid), 128'(0));
        tick();
        b2.m_rdat_m_valid = 1'b0;
        b2.m_finish_mrd   = 1'b0;
        b2.m_finish_wresp = 1'b0;
        check("idle_finish_ignored", 128'({b2.s_finish_wresp, b2.s_finish_mrd}), 128'(0));
        tick();

        // ch1 read with four beats spread over six cycles.
        b2.s_rstart_rq = 2'b10;
        b2.s_rin_addr  = {32'h0000_2000, 32'h0};
        tick();
        b2.s_rstart_rq = 2'b00;
        tick();
        check("r_c2_start", 128'(b2.m_rstart_rq), 128'(1));
        check("r_c2_addr", 128'(b2.m_rin_addr), 128'(32'h0000_2000));
        tick();
        pattern = 6'b011011;
        beats   = 0;
        for (int c = 0; c < 6; c++) begin
            beat = rnd128();
            b2.m_rdat_m_valid = pattern[c];
            b2.m_rdat_m_data  = beat;
            #1;
            check("r_beat_valid", 128'(b2.s_rdat_m_valid), 128'(pattern[c] ? 2'b10 : 2'b00));
            if (b2.s_rdat_m_valid == 2'b10) begin
                beats++;
                check("r_beat_data", b2.s_rdat_m_data, beat);
            end
            tick();
        end
        b2.m_rdat_m_valid = 1'b0;
        check("r_beat_count", 128'(beats), 128'(4));
        b2.m_finish_mrd = 1'b1;
        tick();
        b2.m_finish_mrd = 1'b0;
        check("r_fin_mrd", 128'(b2.s_finish_mrd), 128'(2'b10));
        check("r_fin_wresp", 128'(b2.s_finish_wresp), 128'(0));
        tick();

        // Second ch0 write while pending is dropped and flags overflow.
        b2.s_wstart_rq = 2'b01;
        b2.s_win_addr  = {32'h0, 32'h0000_3000};
        tick();
        b2.s_win_addr  = {32'h0, 32'h0000_4000};
        check("ovf_c1_clear", 128'(b2.s_ovf), 128'(0));
        tick();
        b2.s_wstart_rq = 2'b00;
        check("ovf_set", 128'(b2.s_ovf), 128'(2'b01));
        check("ovf_first_kept", 128'(b2.m_win_addr), 128'(32'h0000_3000));
        starts = 0;
        for (int c = 0; c < 16; c++) begin
            if (b2.m_wstart_rq) starts++;
            b2.m_finish_wresp = (c == 3);
            tick();
        end
        b2.m_finish_wresp = 1'b0;
        check("ovf_one_write", 128'(starts), 128'(1));
        check("ovf_rqfull", 128'(b2.s_rqfull), 128'(0));
        check("ovf_sticky", 128'(b2.s_ovf), 128'(2'b01));

        // Reset during WAIT_R abandons the read silently.
        b2.s_rstart_rq = 2'b01;
        b2.s_rin_addr  = {32'h0, 32'h0000_5000};
        tick();
        b2.s_rstart_rq = 2'b00;
        tick();
        check("rr_start", 128'(b2.m_rstart_rq), 128'(1));
        tick();
        tick();
        rst2 = 1'b1;
        #1;
        check("rr_rqfull", 128'(b2.s_rqfull), 128'(0));
        check("rr_ovf", 128'(b2.s_ovf), 128'(0));
        check("rr_addr", 128'(b2.m_rin_addr), 128'(0));
        tick();
        rst2 = 1'b0;
        b2.m_finish_mrd = 1'b1;
        check("rr_nofin_a", 128'(b2.s_finish_mrd), 128'(0));
        tick();
        b2.m_finish_mrd = 1'b0;
        check("rr_nofin_b", 128'(b2.s_finish_mrd), 128'(0));
        tick();
        check("rr_nofin_c", 128'(b2.s_finish_mrd), 128'(0));
        b2.s_wstart_rq = 2'b01;
        b2.s_win_addr  = {32'h0, 32'h0000_6000};
        tick();
        b2.s_wstart_rq = 2'b00;
        check("rr_new_c1", 128'(b2.m_wstart_rq), 128'(0));
        tick();
        check("rr_new_c2", 128'(b2.m_wstart_rq), 128'(1));
        check("rr_new_addr", 128'(b2.m_win_addr), 128'(32'h0000_6000));
        tick();
        b2.m_finish_wresp = 1'b1;
        tick();
        b2.m_finish_wresp = 1'b0;
        check("rr_new_fin", 128'(b2.s_finish_wresp), 128'(2'b01));

        // NCH=4: all channels read together -> granted 0,1,2,3.
        for (int c = 0; c < 4; c++) begin
            m_wa[c] = '0;
            m_ra[c] = 32'h0000_0100 * (c + 1);
            m_wd[c] = '0;
            m_mk[c] = '0;
        end
        drive4(4'b0000, 4'b1111);
        check("all_rqfull", 128'(b4.s_rqfull), 128'(4'b1111));
        for (int c = 0; c < 4; c++) begin
            t.ch = c; t.wr = 1'b0; t.addr = m_ra[c]; t.data = '0; t.mask = '0;
            serve4(t);
        end
        check("all_done", 128'(b4.s_rqfull), 128'(0));
        model_last = 3;

        // Randomized batches against a transaction-level round-robin model.
        for (int bt = 0; bt < 16; bt++) begin
            pw = '0;
            pr = '0;
            for (int c = 0; c < 4; c++) begin
                kind    = $urandom_range(0, 3);
                pw[c]   = kind[0];
                pr[c]   = kind[1];
                m_wa[c] = $urandom();
                m_ra[c] = $urandom();
                m_wd[c] = rnd128();
                m_mk[c] = MW'($urandom());
            end
            if (pw == 0 && pr == 0) pr[bt % 4] = 1'b1;
            drive4(pw, pr);
            check("batch_rqfull", 128'(b4.s_rqfull), 128'(pw | pr));
            exp_q.delete();
            while ((pw | pr) != 0) begin
                sel = -1;
                for (int off = 1; off <= 4; off++) begin
                    if (sel < 0 && (pw[(model_last + off) % 4] || pr[(model_last + off) % 4]))
                        sel = (model_last + off) % 4;
                end
                t.ch = sel;
                t.wr = pw[sel];
                t.addr = pw[sel] ? m_wa[sel] : m_ra[sel];
                t.data = m_wd[sel];
                t.mask = m_mk[sel];
                if (pw[sel]) pw[sel] = 1'b0;
                else         pr[sel] = 1'b0;
                model_last = sel;
                exp_q.push_back(t);
            end
            foreach (exp_q[i]) serve4(exp_q[i]);
            check("batch_empty", 128'(b4.s_rqfull), 128'(0));
            check("batch_no_ovf", 128'(b4.s_ovf), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_bus_arbiter.md
LINE_BUS_ARBITER -- requirements
Module: line_bus_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of upstream requesters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 128, line data width.
REQ-004 SHALL have parameter MW, default DW/8, byte-mask width.
REQ-005 SHALL have port clk, in, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst, in, 1, asynchronous active-high reset.
REQ-007 SHALL have ports s_wstart_rq / s_rstart_rq, in, NCH, per-channel one-cycle write/read request pulses.
REQ-008 SHALL have ports s_win_addr / s_rin_addr, in, NCH*AW, packed per-channel addresses.
REQ-009 SHALL have ports s_in_wdata and s_in_mask, in, NCH*DW and NCH*MW, packed write data and mask.
REQ-010 SHALL have ports s_finish_wresp / s_finish_mrd, out, NCH, per-channel completion pulses.
REQ-011 SHALL have ports s_rdat_m_data (out, DW, broadcast) and s_rdat_m_valid (out, NCH, per-channel).
REQ-012 SHALL have ports s_rqfull (out, NCH, pending-request flag) and s_ovf (out, NCH, sticky dropped-request flag).
REQ-013 SHALL have downstream outputs m_wstart_rq (1), m_win_addr (AW), m_in_wdata (DW), m_in_mask (MW), m_rstart_rq (1) and m_rin_addr (AW).
REQ-014 SHALL have downstream inputs m_finish_wresp (1), m_rdat_m_data (DW), m_rdat_m_valid (1) and m_finish_mrd (1).

Function
REQ-015 SHALL latch the request type, address, data and mask into per-channel registers on a start pulse; the matching pending bit becomes visible the next cycle.
REQ-016 SHALL drop a start pulse arriving while that channel already has a request pending, and SHALL set s_ovf for that channel (sticky until reset).
REQ-017 SHALL treat simultaneous s_wstart_rq and s_rstart_rq on one channel as write-first: the read is held pending and issued after the write completes.
REQ-018 SHALL implement the FSM IDLE -> ISSUE -> WAIT_W | WAIT_R -> IDLE, with exactly one downstream transaction outstanding.
REQ-019 SHALL, in IDLE with any pending request, select a grant by round robin starting at last_grant+1 (modulo NCH) and register it.
REQ-020 SHALL, in ISSUE, pulse m_wstart_rq or m_rstart_rq for exactly one cycle, driven from the granted channel's registers.
REQ-021 SHALL hold the m_* address, data and mask outputs stable from ISSUE until return to IDLE.
REQ-022 SHALL have a latency of 2 cycles from an upstream start pulse at cycle 0 to the m_*start_rq pulse at cycle 2, when idle with no other pending requests.
REQ-023 SHALL, in WAIT_R, drive s_rdat_m_valid[grant] = m_rdat_m_valid combinationally, with s_rdat_m_data = m_rdat_m_data; all other valid bits SHALL be 0.
REQ-024 SHALL, when m_finish_wresp (in WAIT_W) or m_finish_mrd (in WAIT_R) arrives in cycle k: pulse the registered s_finish_* [grant] in cycle k+1, clear pending, return to IDLE.
REQ-025 SHALL let the set of a new pulse win over the clear when both hit the same channel in the same cycle.
REQ-026 SHALL ignore m_finish_* and m_rdat_m_valid outside the matching WAIT state.
REQ-027 SHALL drive s_rqfull[i] = the OR of channel i's pending bits.

Reset
REQ-028 SHALL, on rst, set: FSM to IDLE; last_grant to NCH-1 (so channel 0 is favoured first); pending and s_ovf to 0; all start/finish/valid outputs to 0; m_* address/data/mask to 0.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction without emitting any s_finish_* pulse.

Structure
REQ-030 SHALL place the FSM state encoding and the default AW/DW/MW constants in a shared package, line_arb_pkg.
REQ-031 SHALL implement round-robin selection in one sub-module, rr_picker (request vector + last grant -> one-hot grant + valid), parametrised by NCH.

Verification
REQ-032 SHALL cover: NCH=2, ch0 write to 0x0000_1000 with mask 0xFFFF -> m_wstart_rq at cycle 2, m_win_addr=0x1000; m_finish_wresp at cycle 6 -> s_finish_wresp=2'b01 at cycle 7.
REQ-033 SHALL cover: NCH=4, all channels read in the same cycle -> grants issued in order 0,1,2,3; each s_finish_mrd pulses once.
REQ-034 SHALL cover: ch1 read with 4 m_rdat_m_valid beats -> s_rdat_m_valid=2'b10 on exactly 4 cycles and s_rdat_m_data equal to m_rdat_m_data on each beat.
REQ-035 SHALL cover: second ch0 write pulse while ch0 is pending -> request dropped, s_ovf[0]=1, one downstream write only.
REQ-036 SHALL cover: rst asserted in WAIT_R -> FSM in IDLE, s_rqfull=0, no s_finish_mrd pulse; a new ch0 request then issues with 2-cycle latency.
